// File: rtl/pu_mac_sequencer.sv
// Dot-product sequencer for one pipelined floating-point MAC PU.
// Clears the accumulator, streams operand reads, drains the pipe, captures P.
module pu_mac_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int PU_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic                  abort,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  pu_clr,
    output logic                  pu_en,
    output logic                  op_zero,
    input  logic [DATA_WIDTH-1:0] pu_p,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] res_data
);

    localparam int DW = $clog2(PU_LAT + 2);
    localparam logic [ADDR_WIDTH:0] LEN_ONE = 1;
    localparam logic [DW-1:0] DR_ONE  = 1;
    localparam logic [DW-1:0] DR_LAST = DW'(PU_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_DRAIN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [DW-1:0]         dcnt_q, dcnt_d;
    logic                  rd_en_q, rd_en_d;
    logic                  pu_clr_q, pu_clr_d;
    logic                  pu_en_q, pu_en_d;
    logic                  op_zero_q, op_zero_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        res_d   = res_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = len;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_d   = '0;
                state_d = (len_q != '0) ? S_ISSUE : S_DONE;
            end
            S_ISSUE: begin
                if (cnt_q == len_q - LEN_ONE) begin
                    dcnt_d  = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + LEN_ONE;
                end
            end
            S_DRAIN: begin
                if (dcnt_q == DR_LAST) begin
                    state_d = S_FLUSH;
                end else begin
                    dcnt_d = dcnt_q + DR_ONE;
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                res_d   = (len_q == '0) ? '0 : pu_p;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Cancel wins over every other transition and suppresses completion.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            res_d   = res_q;
        end
        rd_en_d   = (state_d == S_ISSUE);
        pu_clr_d  = (state_d == S_CLEAR);
        pu_en_d   = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        op_zero_d = (state_q == S_DRAIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q     <= '0;
            cnt_q     <= '0;
            dcnt_q    <= '0;
            rd_en_q   <= 1'b0;
            pu_clr_q  <= 1'b0;
            pu_en_q   <= 1'b0;
            op_zero_q <= 1'b0;
            done_q    <= 1'b0;
            res_q     <= '0;
        end else begin
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            dcnt_q    <= dcnt_d;
            rd_en_q   <= rd_en_d;
            pu_clr_q  <= pu_clr_d;
            pu_en_q   <= pu_en_d;
            op_zero_q <= op_zero_d;
            done_q    <= done_d;
            res_q     <= res_d;
        end
    end

    assign rd_en    = rd_en_q;
    assign rd_addr  = cnt_q[ADDR_WIDTH-1:0];
    assign pu_clr   = pu_clr_q;
    assign pu_en    = pu_en_q;
    assign op_zero  = op_zero_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign res_data = res_q;

endmodule

// File: tb/tb_pu_mac_sequencer.sv
// Bench for pu_mac_sequencer with behavioural operand RAMs and an integer-exact
// fp16 PU model; per-cycle timing checks plus a result scoreboard.
module tb_pu_mac_sequencer;

    localparam int DW  = 16;
    localparam int AW  = 8;
    localparam int LAT = 2;

    typedef struct {
        int          len;
        int          a_base;
        int          a_mod;
        int          b_base;
        int          b_mod;
        logic [15:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [AW:0]   len;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          pu_clr;
    logic          pu_en;
    logic          op_zero;
    logic [DW-1:0] pu_p;
    logic          busy;
    logic          done;
    logic [DW-1:0] res_data;

    int n_vec = 0;
    int n_bad = 0;
    logic [15:0] sb[$];

    logic [15:0] mem_a[256];
    logic [15:0] mem_b[256];
    logic [15:0] ra_q = '0;
    logic [15:0] rb_q = '0;
    int prod_q = 0;
    int acc_q  = 0;

    always #5 clk = ~clk;

    pu_mac_sequencer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .PU_LAT    (LAT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .len     (len),
        .abort   (abort),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .pu_clr  (pu_clr),
        .pu_en   (pu_en),
        .op_zero (op_zero),
        .pu_p    (pu_p),
        .busy    (busy),
        .done    (done),
        .res_data(res_data)
    );

    function automatic int fp2int(input logic [15:0] h);
        int e;
        int m;
        e = int'(h[14:10]);
        if (e == 0) return 0;
        m = int'({1'b1, h[9:0]});
        if (e >= 25) return m <<< (e - 25);
        return m >>> (25 - e);
    endfunction

    function automatic logic [15:0] int2fp(input int v);
        int p;
        int m;
        logic [4:0] e;
        if (v <= 0) return 16'h0000;
        p = 0;
        for (int i = 0; i < 31; i++) if (v[i]) p = i;
        e = 5'(p + 15);
        m = (p >= 10) ? (v >>> (p - 10)) : (v <<< (10 - p));
        return {1'b0, e, m[9:0]};
    endfunction

    // RAMs answer one cycle after rd_en; PU is multiply stage then add stage.
    always @(posedge clk) begin
        if (rd_en) begin
            ra_q <= mem_a[rd_addr];
            rb_q <= mem_b[rd_addr];
        end
        if (pu_clr) begin
            prod_q <= 0;
            acc_q  <= 0;
        end else if (pu_en) begin
            prod_q <= op_zero ? 0 : fp2int(ra_q) * fp2int(rb_q);
            acc_q  <= acc_q + prod_q;
        end
    end

    always_comb pu_p = int2fp(acc_q);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] act_out();
        return {pu_clr, rd_en, (rd_en ? rd_addr : 8'h00),
                pu_en, op_zero, busy, done};
    endfunction

    function automatic logic [13:0] exp_out(input int l, input int c);
        logic pc, re, pe, oz, bz, dn;
        logic [7:0] ad;
        pc = (c == 1);
        re = (l > 0) && (c >= 2) && (c <= l + 1);
        ad = re ? 8'(c - 2) : 8'h00;
        pe = (l > 0) && (c >= 3) && (c <= l + LAT + 3);
        oz = (l > 0) && (c >= l + 3) && (c <= l + LAT + 3);
        bz = (l > 0) ? (c >= 1 && c <= l + LAT + 4) : (c >= 1 && c <= 2);
        dn = (l > 0) ? (c == l + LAT + 5) : (c == 3);
        return {pc, re, ad, pe, oz, bz, dn};
    endfunction

    task automatic fill(input vec_t v);
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = int2fp(v.a_mod == 0 ? v.a_base : (i + v.a_base) % v.a_mod);
            mem_b[i] = int2fp(v.b_mod == 0 ? v.b_base : (i + v.b_base) % v.b_mod);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int td;
        td = (v.len > 0) ? v.len + LAT + 5 : 3;
        fill(v);
        start = 1'b1;
        len   = v.len[AW:0];
        sb.push_back(v.exp);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= td; c++) begin
            chk($sformatf("len%0d cyc%0d", v.len, c),
                32'(act_out()), 32'(exp_out(v.len, c)));
            @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious done", 32'(done), 32'(0));
            end else begin
                chk("res_data", 32'(res_data), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        vec_t vt[6];
        vt[0] = '{3,   1, 16, 4, 16, 16'h5000};
        vt[1] = '{0,   0, 0,  0, 0,  16'h0000};
        vt[2] = '{1,   7, 0,  3, 0,  16'h4D40};
        vt[3] = '{256, 1, 0,  1, 0,  16'h5C00};
        vt[4] = '{5,   0, 16, 2, 0,  16'h4D00};
        vt[5] = '{2,   3, 0,  0, 4,  16'h4200};

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        len   = '0;
        repeat (2) @(negedge clk);
        chk("reset outs", 32'({pu_clr, rd_en, rd_addr, pu_en, op_zero,
                               busy, done, res_data}), 32'(0));
        reset = 1'b0;
        @(negedge clk);

        foreach (vt[i]) run_vec(vt[i]);

        // Abort during the first DRAIN cycle of a len=3 run.
        fill(vt[0]);
        start = 1'b1;
        len   = 9'd3;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("abort run cyc%0d", c),
                32'(act_out()), 32'(exp_out(3, c)));
            if (c < 5) @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort cyc6 busy/rd_en/pu_en", 32'({busy, rd_en, pu_en}), 32'(3'b001));
        @(negedge clk);
        chk("abort cyc7 busy/rd_en/pu_en/op_zero",
            32'({busy, rd_en, pu_en, op_zero}), 32'(0));
        repeat (8) @(negedge clk);
        chk("abort res kept", 32'(res_data), 32'(vt[5].exp));

        // Asynchronous reset in cycle 3 (ISSUE).
        start = 1'b1;
        len   = 9'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reset mid-issue", 32'({pu_clr, rd_en, rd_addr, pu_en, op_zero,
                                    busy, done, res_data}), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        run_vec(vt[0]);

        // Start held high for a whole len=2 run: second run launches off done.
        fill(vt[5]);
        sb.push_back(vt[5].exp);
        sb.push_back(vt[5].exp);
        start = 1'b1;
        len   = 9'd2;
        @(negedge clk);
        for (int c = 1; c <= 9; c++) begin
            chk($sformatf("b2b first cyc%0d", c),
                32'(act_out()), 32'(exp_out(2, c)));
            @(negedge clk);
        end
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            chk($sformatf("b2b second cyc%0d", c),
                32'(act_out()), 32'(exp_out(2, c)));
            @(negedge clk);
        end
        repeat (3) @(negedge clk);

        chk("scoreboard drained", 32'(sb.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
